// File: rtl/frame_mem_pkg.sv
// ----------------------------------------------------------------------------
// frame_mem_pkg
// Shared definitions for the frame RAM arbiter: display window size, RAM
// address width, arbiter state type and the buffered write-request record.
// ----------------------------------------------------------------------------
package frame_mem_pkg;

    localparam int unsigned WIN_W      = 256;
    localparam int unsigned WIN_H      = 256;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DEF_DATA_W = 4;

    // DISPLAY: RAM serves pixel fetches; DRAIN: RAM serves buffered writes.
    typedef enum logic {
        DISPLAY = 1'b0,
        DRAIN   = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]     addr;
        logic [DEF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_req_fifo.sv
// ----------------------------------------------------------------------------
// wr_req_fifo
// Single-clock circular FIFO holding pending RAM write requests.
// Pointers wrap modulo DEPTH (DEPTH must be a power of two, >= 2); the entry
// count is kept in its own register so full and empty are unambiguous.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset, discards all entries
//   i_push       write i_push_data at the tail (ignored when full)
//   i_push_data  entry to store
//   i_pop        drop the head entry (ignored when empty)
//   o_head       current head entry
//   o_count      number of stored entries, 0..DEPTH
//   o_full       count == DEPTH
//   o_empty      count == 0
// ----------------------------------------------------------------------------
module wr_req_fifo #(
    parameter type         ENTRY_T = frame_mem_pkg::wr_req_t,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  ENTRY_T           i_push_data,
    input  logic             i_pop,
    output ENTRY_T           o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    ENTRY_T             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/frame_mem_arbiter.sv
// ----------------------------------------------------------------------------
// frame_mem_arbiter
// Shares the single-port 256x256 frame RAM between the VGA pixel fetch and
// buffered game-logic writes. Inside the display window the RAM is read at
// the current pixel address; outside it, queued writes drain one per cycle.
// All RAM-side outputs are registered (1 cycle latency).
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   DrawX, DrawY      current VGA pixel column / row
//   wr_valid/addr/data  write offer from game logic
//   wr_ready          FIFO has room; transfer on wr_valid && wr_ready
//   mem_address_out   RAM address
//   mem_we, mem_wdata RAM write enable / data
//   pix_valid         mem_address_out is a display fetch this cycle
//   fifo_level        pending write count
//   overflow          sticky: write offered while FIFO was full
// ----------------------------------------------------------------------------
module frame_mem_arbiter #(
    parameter int unsigned DATA_W     = frame_mem_pkg::DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WIN_W      = frame_mem_pkg::WIN_W,
    parameter int unsigned WIN_H      = frame_mem_pkg::WIN_H,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [9:0]                        DrawX,
    input  logic [9:0]                        DrawY,
    input  logic                              wr_valid,
    input  logic [frame_mem_pkg::ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic                              wr_ready,
    output logic [frame_mem_pkg::ADDR_W-1:0]  mem_address_out,
    output logic                              mem_we,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic                              pix_valid,
    output logic [LVL_W-1:0]                  fifo_level,
    output logic                              overflow
);

    import frame_mem_pkg::*;

    // Entry record sized by this instance's DATA_W.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic               w_in_win;

    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_overflow;

    logic [ADDR_W-1:0]  w_nxt_addr;
    logic               w_nxt_we;
    logic [DATA_W-1:0]  w_nxt_wdata;

    logic               w_push;
    logic               w_pop;
    req_t               w_push_req;
    req_t               w_head;
    logic [LVL_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;

    // ------------------------------------------------------------------
    // Window compare and write-side handshake
    // ------------------------------------------------------------------
    assign w_in_win   = (32'(DrawX) < WIN_W) && (32'(DrawY) < WIN_H);

    assign wr_ready   = !w_full;
    assign w_push     = wr_valid && wr_ready;
    assign w_push_req = '{addr: wr_addr, data: wr_data};

    wr_req_fifo #(
        .ENTRY_T (req_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_push      (w_push),
        .i_push_data (w_push_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // State register: the registered form of the window flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= DRAIN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = w_in_win ? DISPLAY : DRAIN;
    end

    // ------------------------------------------------------------------
    // Output decode. Because the RAM outputs are registered, they are
    // decoded from the state being entered, so the registered outputs and
    // r_state always describe the same cycle. The pop therefore follows
    // the current window flag and never collides with a display fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_pop       = 1'b0;
        w_nxt_addr  = '0;
        w_nxt_we    = 1'b0;
        w_nxt_wdata = '0;
        case (w_next_state)
            DISPLAY: begin
                // x + 256*y within the 256x256 frame
                w_nxt_addr = {DrawY[7:0], DrawX[7:0]};
            end
            DRAIN: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nxt_addr  = w_head.addr;
                    w_nxt_we    = 1'b1;
                    w_nxt_wdata = w_head.data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_addr  <= w_nxt_addr;
            r_we    <= w_nxt_we;
            r_wdata <= w_nxt_wdata;
            if (wr_valid && !wr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign mem_address_out = r_addr;
    assign mem_we          = r_we;
    assign mem_wdata       = r_wdata;
    assign pix_valid       = (r_state == DISPLAY);
    assign fifo_level      = w_count;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
module tb_frame_mem_arbiter;

    localparam int DW    = 4;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [9:0]    DrawX;
    logic [9:0]    DrawY;
    logic          wr_valid;
    logic [15:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [15:0]   mem_address_out;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          pix_valid;
    logic [3:0]    fifo_level;
    logic          overflow;

    frame_mem_arbiter #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .WIN_W      (256),
        .WIN_H      (256)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .wr_valid        (wr_valid),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .mem_address_out (mem_address_out),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .pix_valid       (pix_valid),
        .fifo_level      (fifo_level),
        .overflow        (overflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of pending writes plus the expected
    // registered RAM-side outputs for the cycle after the coming edge.
    typedef struct {
        logic [15:0]   a;
        logic [DW-1:0] d;
    } req_t;

    req_t          q[$];
    logic          m_ovf = 1'b0;
    logic [15:0]   e_addr;
    logic          e_we;
    logic [DW-1:0] e_wdata;
    logic          e_pix;

    // Drive one cycle of inputs, advance the model, clock, then compare
    // every output against the model.
    task automatic step(input bit rst, input int x, input int y, input bit v,
                        input logic [15:0] a, input logic [DW-1:0] d);
        bit   inwin;
        bit   room;
        req_t e;
        RESET    = rst;
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        inwin = (x < 256) && (y < 256);
        e_addr  = '0;
        e_we    = 1'b0;
        e_wdata = '0;
        e_pix   = 1'b0;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            room = (q.size() < DEPTH);
            if (v && !room) m_ovf = 1'b1;
            if (inwin) begin
                e_addr = 16'(x + 256 * y);
                e_pix  = 1'b1;
            end else if (q.size() > 0) begin
                e       = q.pop_front();
                e_addr  = e.a;
                e_wdata = e.d;
                e_we    = 1'b1;
            end
            if (v && room) q.push_back('{a, d});
        end
        @(posedge CLK);
        #1;
        check("m_addr",  mem_address_out, e_addr);
        check("m_we",    mem_we, e_we);
        check("m_wdata", mem_wdata, e_wdata);
        check("m_pix",   pix_valid, e_pix);
        check("m_level", fifo_level, q.size());
        check("m_ready", wr_ready, (q.size() < DEPTH));
        check("m_ovf",   overflow, m_ovf);
    endtask

    typedef struct {
        int            x;
        int            y;
        bit            v;
        logic [15:0]   a;
        logic [DW-1:0] d;
        logic [15:0]   ea;
        bit            ewe;
        logic [DW-1:0] ed;
        bit            epix;
        int            elvl;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int x;
        int y;

        tbl[0] = '{254, 3,  1'b0, 16'h0000, 4'd0, 16'd1022, 1'b0, 4'd0, 1'b1, 0};
        tbl[1] = '{255, 3,  1'b0, 16'h0000, 4'd0, 16'd1023, 1'b0, 4'd0, 1'b1, 0};
        tbl[2] = '{256, 3,  1'b0, 16'h0000, 4'd0, 16'd0,    1'b0, 4'd0, 1'b0, 0};
        tbl[3] = '{10,  10, 1'b1, 16'h0100, 4'd1, 16'd2570, 1'b0, 4'd0, 1'b1, 1};
        tbl[4] = '{10,  10, 1'b1, 16'h0200, 4'd2, 16'd2570, 1'b0, 4'd0, 1'b1, 2};
        tbl[5] = '{10,  10, 1'b1, 16'h0300, 4'd3, 16'd2570, 1'b0, 4'd0, 1'b1, 3};
        tbl[6] = '{300, 10, 1'b0, 16'h0000, 4'd0, 16'h0100, 1'b1, 4'd1, 1'b0, 2};
        tbl[7] = '{300, 10, 1'b0, 16'h0000, 4'd0, 16'h0200, 1'b1, 4'd2, 1'b0, 1};
        tbl[8] = '{300, 10, 1'b0, 16'h0000, 4'd0, 16'h0300, 1'b1, 4'd3, 1'b0, 0};
        tbl[9] = '{300, 10, 1'b0, 16'h0000, 4'd0, 16'd0,    1'b0, 4'd0, 1'b0, 0};

        RESET = 1'b1; DrawX = '0; DrawY = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset for two cycles, release at pixel (0,0)
        step(1, 0, 0, 0, 16'h0, 4'h0);
        step(1, 0, 0, 0, 16'h0, 4'h0);
        step(0, 0, 0, 0, 16'h0, 4'h0);
        check("rst_addr",  mem_address_out, 0);
        check("rst_pix",   pix_valid, 1);
        check("rst_we",    mem_we, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_level", fifo_level, 0);

        // Window-edge sweep and in-order drain of three writes
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_addr", i),  mem_address_out, tbl[i].ea);
            check($sformatf("tbl%0d_we", i),    mem_we, tbl[i].ewe);
            check($sformatf("tbl%0d_wdata", i), mem_wdata, tbl[i].ed);
            check($sformatf("tbl%0d_pix", i),   pix_valid, tbl[i].epix);
            check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].elvl);
        end

        // Fill to full in the window, then offer a ninth write
        for (int i = 0; i < 8; i++) step(0, 10, 10, 1, 16'h1000 + 16'(i), 4'(i));
        check("full_ready", wr_ready, 0);
        check("full_level", fifo_level, 8);
        step(0, 10, 10, 1, 16'hDEAD, 4'hF);
        check("ovf_set",   overflow, 1);
        check("ovf_level", fifo_level, 8);
        check("ovf_we",    mem_we, 0);

        // First drain cycle pops entry 0; the next cycle pushes and pops
        step(0, 300, 10, 0, 16'h0, 4'h0);
        check("dr0_addr",  mem_address_out, 16'h1000);
        check("dr0_level", fifo_level, 7);
        step(0, 300, 10, 1, 16'h2222, 4'hA);
        check("pp_addr",  mem_address_out, 16'h1001);
        check("pp_level", fifo_level, 7);
        for (int i = 2; i < 8; i++) begin
            step(0, 300, 10, 0, 16'h0, 4'h0);
            check($sformatf("dr%0d_addr", i), mem_address_out, 16'h1000 + 16'(i));
            check($sformatf("dr%0d_data", i), mem_wdata, 4'(i));
        end
        step(0, 300, 10, 0, 16'h0, 4'h0);
        check("pp_last_addr", mem_address_out, 16'h2222);
        check("pp_last_data", mem_wdata, 4'hA);
        step(0, 300, 10, 0, 16'h0, 4'h0);
        check("dr_done_we", mem_we, 0);
        check("ovf_sticky", overflow, 1);

        // Reset with five pending writes, in a drain cycle, with a push
        for (int i = 0; i < 5; i++) step(0, 20, 20, 1, 16'h3000 + 16'(i), 4'(i + 1));
        step(1, 300, 10, 1, 16'hBEEF, 4'h5);
        check("mrst_we",    mem_we, 0);
        check("mrst_level", fifo_level, 0);
        check("mrst_ovf",   overflow, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 300, 10, 0, 16'h0, 4'h0);
            check($sformatf("mrst_nowr%0d", i), mem_we, 0);
        end

        // Randomized traffic around the window edges
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       x = int'($urandom_range(0, 799));
                1:       x = int'($urandom_range(250, 262));
                2:       x = int'($urandom_range(0, 255));
                default: x = int'($urandom_range(256, 799));
            endcase
            if ($urandom_range(0, 3) == 0) y = int'($urandom_range(0, 524));
            else                           y = int'($urandom_range(250, 260));
            step($urandom_range(0, 99) == 0, x, y, $urandom_range(0, 1) == 1,
                 16'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
